pipeline_ctrl_unit: RTL and testbench

//  Central sequencer for the 5-stage pipeline. Drives PC, IF/ID and ID/EX enables and flushes.

---
 rtl/pipeline_ctrl_unit_pkg.sv | 18 +
 rtl/pipeline_ctrl_unit_if.sv | 34 +++
 rtl/pipeline_ctrl_unit_hazard_detect.sv | 18 +
 rtl/pipeline_ctrl_unit.sv | 131 +++++++++++++
 tb/tb_pipeline_ctrl_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_unit_pkg.sv
// rtl/pipeline_ctrl_unit_pkg.sv - state encodings and push source codes for the pipeline sequencer
package pipeline_ctrl_unit_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PUSH_HI  = 3'd2,
    ST_PUSH_LO  = 3'd3,
    ST_PUSH_CCR = 3'd4,
    ST_VECTOR   = 3'd5
  } state_e;

  localparam logic [1:0] PUSH_NONE  = 2'd0;
  localparam logic [1:0] PUSH_PC_HI = 2'd1;
  localparam logic [1:0] PUSH_PC_LO = 2'd2;
  localparam logic [1:0] PUSH_CCR   = 2'd3;

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// rtl/pipeline_ctrl_unit_if.sv - hazard/interrupt inputs and pipeline control outputs of the sequencer
interface pipeline_ctrl_unit_if #(
  parameter int REG_AW = 3
);

  logic              int_req;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rd;
  logic              id_uses_rs;
  logic              id_uses_rd;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [1:0]        push_sel;
  logic              int_load_vector;
  logic              int_ack;
  logic              busy;

  // master is the pipeline side, slave is the sequencer
  modport master (
    output int_req, id_rs, id_rd, id_uses_rs, id_uses_rd, ex_mem_read, ex_rd, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, push_sel, int_load_vector, int_ack, busy
  );

  modport slave (
    input  int_req, id_rs, id_rd, id_uses_rs, id_uses_rd, ex_mem_read, ex_rd, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, push_sel, int_load_vector, int_ack, busy
  );

endinterface

// File: rtl/pipeline_ctrl_unit_hazard_detect.sv
// rtl/pipeline_ctrl_unit_hazard_detect.sv - load-use hazard compare between decode and execute
module pipeline_ctrl_unit_hazard_detect #(
  parameter int REG_AW = 3
) (
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rd,
  output logic              o_load_use
);

  assign o_load_use = i_ex_mem_read &
                      ((i_id_uses_rs & (i_ex_rd == i_id_rs)) |
                       (i_id_uses_rd & (i_ex_rd == i_id_rd)));

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// rtl/pipeline_ctrl_unit.sv - pipeline sequencer: stalls, jump squash and interrupt entry
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_AW       = 3
) (
  input  logic                 clk,
  input  logic                 RESET,
  pipeline_ctrl_unit_if.slave  bus
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_pending;
  logic          w_pending_nxt;
  logic          w_load_use;

  logic          w_pc_write;
  logic          w_if_id_write;
  logic          w_if_id_flush;
  logic          w_id_ex_flush;
  logic [1:0]    w_push_sel;
  logic          w_int_load_vector;
  logic          w_int_ack;

  pipeline_ctrl_unit_hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_rd       (bus.ex_rd),
    .i_id_rs       (bus.id_rs),
    .i_id_rd       (bus.id_rd),
    .i_id_uses_rs  (bus.id_uses_rs),
    .i_id_uses_rd  (bus.id_uses_rd),
    .o_load_use    (w_load_use)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_pending_nxt     = r_pending;
    w_pc_write        = 1'b1;
    w_if_id_write     = 1'b1;
    w_if_id_flush     = 1'b0;
    w_id_ex_flush     = 1'b0;
    w_push_sel        = PUSH_NONE;
    w_int_load_vector = 1'b0;
    w_int_ack         = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.int_req) w_pending_nxt = 1'b1;
        if (bus.ex_branch_taken) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
        end else if (r_pending || bus.int_req) begin
          w_pc_write    = 1'b0;
          w_if_id_flush = 1'b1;
          w_cnt_nxt     = DRAIN_INIT;
          w_state_nxt   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // an older jump still resolving in execute must land its target in PC
        w_pc_write    = bus.ex_branch_taken;
        w_id_ex_flush = bus.ex_branch_taken;
        w_if_id_flush = 1'b1;
        if (r_cnt == '0) w_state_nxt = ST_PUSH_HI;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      ST_PUSH_HI: begin
        w_push_sel    = PUSH_PC_HI;
        w_pc_write    = 1'b0;
        w_if_id_flush = 1'b1;
        w_state_nxt   = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        w_push_sel    = PUSH_PC_LO;
        w_pc_write    = 1'b0;
        w_if_id_flush = 1'b1;
        w_state_nxt   = ST_PUSH_CCR;
      end
      ST_PUSH_CCR: begin
        w_push_sel    = PUSH_CCR;
        w_pc_write    = 1'b0;
        w_if_id_flush = 1'b1;
        w_state_nxt   = ST_VECTOR;
      end
      ST_VECTOR: begin
        w_int_load_vector = 1'b1;
        w_int_ack         = 1'b1;
        w_if_id_flush     = 1'b1;
        w_pending_nxt     = 1'b0;
        w_state_nxt       = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign bus.pc_write        = w_pc_write;
  assign bus.if_id_write     = w_if_id_write;
  assign bus.if_id_flush     = w_if_id_flush;
  assign bus.id_ex_flush     = w_id_ex_flush;
  assign bus.push_sel        = w_push_sel;
  assign bus.int_load_vector = w_int_load_vector;
  assign bus.int_ack         = w_int_ack;
  assign bus.busy            = (r_state != ST_RUN);

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb/tb_pipeline_ctrl_unit.sv - randomized and directed bench against a phase-count reference model
module tb_pipeline_ctrl_unit;

  localparam int D = 3;

  logic clk;
  logic RESET;

  pipeline_ctrl_unit_if #(.REG_AW(3)) bus ();

  pipeline_ctrl_unit #(
    .DRAIN_CYCLES (D),
    .REG_AW       (3)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ack_cyc = -1;
  int ack_cnt = 0;
  int t0;

  // model: phase 0 is normal running, 1..D drain, D+1..D+3 pushes, D+4 vector
  int m_phase = 0;
  bit m_pend = 1'b0;

  bit g_rst, g_int, g_mr, g_urs, g_urd, g_br;
  logic [2:0] g_rs, g_rd, g_exrd;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    g_rst = 0; g_int = 0; g_mr = 0; g_urs = 0; g_urd = 0; g_br = 0;
    g_rs = 0; g_rd = 0; g_exrd = 0;
  endtask

  task automatic step();
    bit lu;
    int e_pc, e_ifw, e_iff, e_idf, e_push, e_vec, e_ack, e_busy, n_phase;
    bit n_pend;
    @(negedge clk);
    RESET = g_rst;
    bus.int_req = g_int;
    bus.ex_mem_read = g_mr;
    bus.id_uses_rs = g_urs;
    bus.id_uses_rd = g_urd;
    bus.ex_branch_taken = g_br;
    bus.id_rs = g_rs;
    bus.id_rd = g_rd;
    bus.ex_rd = g_exrd;
    #1;
    if (g_rst) begin m_phase = 0; m_pend = 0; end
    lu = g_mr && ((g_urs && g_exrd == g_rs) || (g_urd && g_exrd == g_rd));
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_push = 0; e_vec = 0; e_ack = 0;
    e_busy = (m_phase != 0);
    n_phase = m_phase; n_pend = m_pend;
    if (m_phase == 0) begin
      n_pend = m_pend | g_int;
      if (g_br) begin e_iff = 1; e_idf = 1; end
      else if (lu) begin e_pc = 0; e_ifw = 0; e_idf = 1; end
      else if (m_pend || g_int) begin e_pc = 0; e_iff = 1; n_phase = 1; end
    end else if (m_phase <= D) begin
      e_pc = g_br; e_idf = g_br; e_iff = 1; n_phase = m_phase + 1;
    end else if (m_phase <= D + 3) begin
      e_push = m_phase - D; e_pc = 0; e_iff = 1; n_phase = m_phase + 1;
    end else begin
      e_vec = 1; e_ack = 1; e_iff = 1; n_phase = 0; n_pend = 0;
    end
    chk("pc_write", bus.pc_write, e_pc);
    chk("if_id_write", bus.if_id_write, e_ifw);
    chk("if_id_flush", bus.if_id_flush, e_iff);
    chk("id_ex_flush", bus.id_ex_flush, e_idf);
    chk("push_sel", bus.push_sel, e_push);
    chk("int_load_vector", bus.int_load_vector, e_vec);
    chk("int_ack", bus.int_ack, e_ack);
    chk("busy", bus.busy, e_busy);
    if (bus.int_ack === 1'b1) begin
      ack_cnt++;
      if (ack_cyc < 0) ack_cyc = cyc;
    end
    if (g_rst) begin n_phase = 0; n_pend = 0; end
    m_phase = n_phase;
    m_pend = n_pend;
    cyc++;
  endtask

  initial begin
    RESET = 1'b1;
    bus.int_req = 0; bus.ex_mem_read = 0; bus.id_uses_rs = 0; bus.id_uses_rd = 0;
    bus.ex_branch_taken = 0; bus.id_rs = 0; bus.id_rd = 0; bus.ex_rd = 0;
    idle();
    g_rst = 1;
    step();
    g_rst = 0;
    step();

    // load-use on Rs, then a non-matching destination
    g_mr = 1; g_exrd = 3; g_rs = 3; g_urs = 1;
    step();
    g_exrd = 4;
    step();

    // jump outranks load-use
    g_exrd = 3; g_br = 1;
    step();
    idle();
    step();

    // single-cycle request, basic latency
    ack_cyc = -1; t0 = cyc; g_int = 1;
    step();
    g_int = 0;
    repeat (9) step();
    chk("ack_latency", ack_cyc - t0, D + 4);

    // jump during the second drain cycle keeps latency
    ack_cyc = -1; t0 = cyc; g_int = 1;
    step();
    g_int = 0;
    step();
    g_br = 1;
    step();
    g_br = 0;
    repeat (7) step();
    chk("ack_latency_br", ack_cyc - t0, D + 4);

    // reset while pushing PC low half cancels the sequence
    ack_cnt = 0; g_int = 1;
    step();
    g_int = 0;
    repeat (4) step();
    g_rst = 1;
    step();
    g_rst = 0;
    repeat (10) step();
    chk("ack_after_reset", ack_cnt, 0);

    // held request: back-to-back sequences with one running cycle between
    ack_cyc = -1; ack_cnt = 0; t0 = cyc; g_int = 1;
    repeat (12) step();
    chk("ack_latency_held", ack_cyc - t0, D + 4);
    g_int = 0;
    repeat (10) step();
    chk("ack_count_held", ack_cnt, 2);

    for (int i = 0; i < 3000; i++) begin
      g_rst  = ($urandom_range(0, 99) == 0);
      g_int  = ($urandom_range(0, 7) == 0);
      g_br   = ($urandom_range(0, 5) == 0);
      g_mr   = $urandom_range(0, 1);
      g_urs  = $urandom_range(0, 1);
      g_urd  = $urandom_range(0, 1);
      g_rs   = 3'($urandom_range(0, 7));
      g_rd   = 3'($urandom_range(0, 7));
      g_exrd = 3'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
